// File: rtl/ysyx_22051145_if_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the decode handshake.
// master = fetch stage side, slave = memory/decode side.
interface ysyx_22051145_if_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_inst;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );
endinterface

// File: rtl/ysyx_22051145_if_stage.sv
// Instruction fetch stage: owns the fetch PC, one outstanding imem read, small {pc, inst} FIFO.
// Define YSYX_22051145_IF_PERF_EN to add fetch/flush performance counters.
module ysyx_22051145_if_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag,
    input  logic [63:0] jump_addr,
    ysyx_22051145_if_stage_if.master bus
`ifdef YSYX_22051145_IF_PERF_EN
    ,
    output logic [63:0] perf_fetch_cnt,
    output logic [63:0] perf_flush_cnt
`endif
);

    localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Depth = CntW'(BUF_DEPTH);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

    state_e          state_q, state_d;
    logic [63:0]     fetch_pc_q, fetch_pc_d;
    logic [63:0]     out_pc_q, out_pc_d;
    logic [CntW-1:0] count_q, count_d, count_post;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [63:0]     buf_pc_q   [BUF_DEPTH];
    logic [31:0]     buf_inst_q [BUF_DEPTH];

    logic req_fire, push, pop;
    logic unused_addr_bits;

    assign unused_addr_bits = ^jump_addr[1:0];

    assign req_fire = (state_q == StReq) && bus.imem_req_ready;
    assign pop      = (count_q != '0) && bus.if_ready;
    // Responses landing in a redirect cycle belong to the old stream.
    assign push     = (state_q == StWait) && bus.imem_rsp_valid && !jump_flag;
    assign count_post = count_q + CntW'(push) - CntW'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (jump_flag) begin
            unique case (state_q)
                StIdle:  state_d = StReq;
                StReq:   state_d = req_fire ? StDrop : StReq;
                StWait:  state_d = bus.imem_rsp_valid ? StReq : StDrop;
                StDrop:  state_d = bus.imem_rsp_valid ? StReq : StDrop;
                default: state_d = StIdle;
            endcase
        end else begin
            unique case (state_q)
                StIdle: if (count_q < Depth) state_d = StReq;
                StReq:  if (req_fire) state_d = StWait;
                StWait: begin
                    if (bus.imem_rsp_valid) begin
                        state_d = (count_post < Depth) ? StReq : StIdle;
                    end
                end
                StDrop: if (bus.imem_rsp_valid) state_d = StReq;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        bus.imem_req_valid = (state_q == StReq);
        bus.imem_req_addr  = fetch_pc_q;
        bus.if_valid       = (count_q != '0);
        bus.if_pc          = '0;
        bus.if_inst        = '0;
        if (count_q != '0) begin
            bus.if_pc   = buf_pc_q[rd_ptr_q];
            bus.if_inst = buf_inst_q[rd_ptr_q];
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        out_pc_d   = out_pc_q;
        count_d    = count_post;
        rd_ptr_d   = rd_ptr_q + PtrW'(pop);
        wr_ptr_d   = wr_ptr_q + PtrW'(push);
        if (jump_flag) begin
            fetch_pc_d = {jump_addr[63:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else if (req_fire) begin
            out_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 64'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            out_pc_q   <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_pc_q   <= out_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage needs no reset: head outputs are gated by count.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_q[wr_ptr_q]   <= out_pc_q;
            buf_inst_q[wr_ptr_q] <= bus.imem_rsp_data;
        end
    end

`ifdef YSYX_22051145_IF_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (push) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            if (jump_flag) perf_flush_cnt <= perf_flush_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22051145_if_stage.sv
// Bench for ysyx_22051145_if_stage: directed scenarios plus a randomized run checked against
// an in-order instruction-stream model and a one-outstanding memory model.
module tb_ysyx_22051145_if_stage;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_flag;
    logic [63:0] jump_addr;
`ifdef YSYX_22051145_IF_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    ysyx_22051145_if_stage_if bus ();

    ysyx_22051145_if_stage #(
        .RESET_PC (RESET_PC),
        .BUF_DEPTH(2)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .jump_flag(jump_flag),
        .jump_addr(jump_addr),
        .bus      (bus)
`ifdef YSYX_22051145_IF_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9bdf;
    endfunction

    // Stimulus knobs
    int p_if_ready, p_req_ready, p_jump;
    int unsigned lat_min, lat_max;
    int hs_limit;

    // Reference model: expected next PC of the delivered stream and the memory's pending read
    logic [63:0] exp_pc;
    logic        pend;
    int          pend_left;
    logic [63:0] pend_addr;
    logic [63:0] hs_log[$];
    logic [63:0] pop_log[$];
    int          pop_step[$];
    int          step_no;
    logic        prev_stall;
    logic [63:0] prev_pc;
    logic [31:0] prev_inst;

    // Called at a falling edge: observe, drive inputs for the next rising edge, advance one cycle.
    task automatic step(input logic jf, input logic [63:0] ja);
        logic hs, pop, rspv;
        if (prev_stall) begin
            check("hold_valid", bus.if_valid, 1);
            check("hold_pc", bus.if_pc, prev_pc);
            check("hold_inst", bus.if_inst, prev_inst);
        end
        if (bus.imem_req_valid) check("req_align", bus.imem_req_addr[1:0], 0);
        rspv = 1'b0;
        if (pend) begin
            pend_left--;
            if (pend_left == 0) begin
                rspv = 1'b1;
                pend = 1'b0;
            end
        end
        bus.imem_rsp_valid = rspv;
        bus.imem_rsp_data  = rspv ? mem_word(pend_addr) : $urandom;
        bus.imem_req_ready = (hs_log.size() < hs_limit) &&
                             (int'($urandom_range(99)) < p_req_ready);
        bus.if_ready       = int'($urandom_range(99)) < p_if_ready;
        jump_flag          = jf || (int'($urandom_range(99)) < p_jump);
        jump_addr          = jf ? ja : {$urandom, $urandom};
        hs  = bus.imem_req_valid && bus.imem_req_ready;
        pop = bus.if_valid && bus.if_ready;
        if (pop) begin
            check("pop_pc", bus.if_pc, exp_pc);
            check("pop_inst", bus.if_inst, mem_word(exp_pc));
            pop_log.push_back(bus.if_pc);
            pop_step.push_back(step_no);
            exp_pc += 64'd4;
        end
        if (hs) begin
            check("one_outstanding", pend, 0);
            pend      = 1'b1;
            pend_left = int'($urandom_range(lat_max, lat_min));
            pend_addr = bus.imem_req_addr;
            hs_log.push_back(bus.imem_req_addr);
        end
        if (jump_flag) exp_pc = {jump_addr[63:2], 2'b00};
        prev_stall = bus.if_valid && !bus.if_ready && !jump_flag;
        prev_pc    = bus.if_pc;
        prev_inst  = bus.if_inst;
        @(negedge clk);
        step_no++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 64'd0);
    endtask

    task automatic clear_model();
        exp_pc     = RESET_PC;
        prev_stall = 1'b0;
        hs_log.delete();
        pop_log.delete();
        pop_step.delete();
        step_no    = 0;
    endtask

    task automatic reset_sync();
        rst = 1'b1;
        jump_flag = 1'b0;
        jump_addr = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.if_ready       = 1'b0;
        pend = 1'b0;
        pend_left = 0;
        pend_addr = '0;
        p_if_ready = 100; p_req_ready = 100; p_jump = 0;
        lat_min = 1; lat_max = 1; hs_limit = 1 << 30;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Test 1: streaming with single-cycle memory
        reset_sync();
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_if_valid", bus.if_valid, 0);
        check("rst_if_pc", bus.if_pc, 0);
        check("rst_if_inst", bus.if_inst, 0);
        check("rst_req_addr", bus.imem_req_addr, RESET_PC);
        run(8);
        check("t1_hs_n", hs_log.size(), 4);
        check("t1_pop_n", pop_log.size(), 3);
        if (hs_log.size() >= 3 && pop_log.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                check("t1_req_addr", hs_log[i], RESET_PC + 64'(4 * i));
                check("t1_if_pc", pop_log[i], RESET_PC + 64'(4 * i));
            end
            check("t1_first_latency", pop_step[0], 3);
            check("t1_throughput", pop_step[1] - pop_step[0], 2);
        end

        // Test 2: decode stalled, buffer fills then fetch resumes
        reset_sync();
        p_if_ready = 0;
        run(12);
        check("t2_pushes", hs_log.size(), 2);
        check("t2_head_valid", bus.if_valid, 1);
        check("t2_head_pc", bus.if_pc, RESET_PC);
        check("t2_req_idle", bus.imem_req_valid, 0);
        p_if_ready = 100;
        run(10);
        check("t2_resume_n", hs_log.size() >= 3, 1);
        if (hs_log.size() >= 3) check("t2_resume_addr", hs_log[2], RESET_PC + 64'd8);

        // Test 3: redirect while waiting, response three cycles later
        reset_sync();
        p_if_ready = 0;
        run(3);
        lat_min = 4; lat_max = 4;
        run(1);
        step(1'b1, 64'h0000_0000_8000_1003);
        check("t3_flushed", bus.if_valid, 0);
        run(3);
        check("t3_req_valid", bus.imem_req_valid, 1);
        check("t3_req_addr", bus.imem_req_addr, 64'h0000_0000_8000_1000);
        lat_min = 1; lat_max = 1; p_if_ready = 100;
        run(6);
        check("t3_pop_n", pop_log.size() >= 1, 1);
        if (pop_log.size() >= 1) check("t3_first_pc", pop_log[0], 64'h0000_0000_8000_1000);

        // Test 4: redirect coinciding with the response
        reset_sync();
        run(2);
        step(1'b1, 64'h0000_0000_8000_2000);
        check("t4_req_valid", bus.imem_req_valid, 1);
        check("t4_req_addr", bus.imem_req_addr, 64'h0000_0000_8000_2000);
        check("t4_not_pushed", bus.if_valid, 0);
        run(6);
        if (pop_log.size() >= 1) check("t4_first_pc", pop_log[0], 64'h0000_0000_8000_2000);

        // Test 5: asynchronous reset mid-wait with a late response
        reset_sync();
        p_if_ready = 0;
        run(3);
        lat_min = 5; lat_max = 5;
        run(1);
        check("t5_pre_valid", bus.if_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_async_req_valid", bus.imem_req_valid, 0);
        check("t5_async_if_valid", bus.if_valid, 0);
        check("t5_async_if_pc", bus.if_pc, 0);
        check("t5_async_if_inst", bus.if_inst, 0);
        check("t5_async_req_addr", bus.imem_req_addr, RESET_PC);
        clear_model();
        p_req_ready = 0;
        @(negedge clk);
        run(2);
        rst = 1'b0;
        run(4);
        check("t5_late_rsp_sent", pend, 0);
        p_req_ready = 100; p_if_ready = 100; lat_min = 1; lat_max = 1;
        run(6);
        if (hs_log.size() >= 1) check("t5_first_req", hs_log[0], RESET_PC);
        check("t5_pop_n", pop_log.size() >= 1, 1);
        if (pop_log.size() >= 1) check("t5_first_pc", pop_log[0], RESET_PC);

        // Test 6: PC wrap at the top of the address space
        reset_sync();
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFF9);
        run(12);
        check("t6_pop_n", pop_log.size() >= 4, 1);
        if (pop_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t6_wrap_pc", pop_log[i], 64'hFFFF_FFFF_FFFF_FFF8 + 64'(4 * i));
            end
        end

`ifdef YSYX_22051145_IF_PERF_EN
        // Test 7: performance counters
        reset_sync();
        hs_limit = 5;
        run(14);
        step(1'b1, 64'h0000_0000_8000_3000);
        step(1'b1, 64'h0000_0000_8000_3000);
        check("perf_fetch", perf_fetch_cnt, 5);
        check("perf_flush", perf_flush_cnt, 2);
`endif

        // Randomized run against the stream model
        reset_sync();
        p_if_ready = 70; p_req_ready = 70; p_jump = 4;
        lat_min = 1; lat_max = 4;
        run(1500);
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
        run(1500);
        check("rand_progress", pop_log.size() > 200, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_22051145_if_stage.md
Name: ysyx_22051145_if_stage

Overview:
- Instruction fetch stage of the ysyx_22051145 core, at the front of the pipeline.
- Consumes the execute stage's redirect outputs (jump_flag / jump_addr) and owns the fetch PC.
- Issues one-outstanding instruction-memory reads over a valid/ready request and valid-only response.
- Buffers fetched {pc, inst} pairs in a small FIFO that feeds decode over a valid/ready handshake.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, fetch PC after reset.
- BUF_DEPTH, 2, instruction buffer entries (power of two, ≥2).

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- jump_flag  input  1  redirect request from execute stage
- jump_addr  input  64  redirect target
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  64  fetch address, bits [1:0] always 0
- imem_rsp_valid  input  1  read data valid (one per accepted request, ≥1 cycle after accept)
- imem_rsp_data  input  32  instruction word
- if_valid  output  1  buffer head valid to decode
- if_ready  input  1  decode accepts head
- if_pc  output  64  PC of head instruction
- if_inst  output  32  head instruction

Behaviour:
- Reset (asynchronous assert, released synchronously by clk):
  - fetch_pc = RESET_PC; state = IDLE; buffer count = 0.
  - imem_req_valid = 0, if_valid = 0, if_pc = 0, if_inst = 0, imem_req_addr = RESET_PC.
- Outputs:
  - imem_req_valid = (state == REQ); imem_req_addr = fetch_pc.
  - if_valid = (count != 0); if_pc / if_inst = buffer head, held stable while if_valid && !if_ready.
- Space: slots_free = BUF_DEPTH − count − (state ∈ {WAIT}).
- FSM, no redirect:
  - IDLE: go to REQ when count < BUF_DEPTH.
  - REQ: on imem_req_valid && imem_req_ready → latch out_pc = fetch_pc, fetch_pc += 4, go to WAIT.
  - WAIT: on imem_rsp_valid → push {out_pc, imem_rsp_data}; next state is REQ if (count after push/pop) < BUF_DEPTH, else IDLE.
  - DROP: on imem_rsp_valid → discard data, go to REQ.
- Fetch latency: request accepted in cycle N, response in cycle N+k → if_valid earliest at N+k+1.
- Redirect (jump_flag = 1) has priority over all other events in the same cycle:
  - fetch_pc <= {jump_addr[63:2], 2'b00}.
  - Buffer flushed: count = 0 next cycle; a pop in the same cycle is still honoured by decode but its data is ignored.
  - REQ with handshake firing this cycle → DROP (the accepted request will return a response that must be discarded).
  - REQ without handshake → stay in REQ; the address changes next cycle. Memory tolerates a withdrawn or changed unaccepted request.
  - WAIT with imem_rsp_valid this cycle → data discarded, go to REQ.
  - WAIT without response → DROP.
  - DROP with response → REQ; DROP without response → stay in DROP.
  - IDLE → REQ.
- Buffer:
  - Circular FIFO; pointers wrap modulo BUF_DEPTH.
  - A push at full cannot occur, because requests are issued only when slots_free > 0.
  - Simultaneous push and pop leaves count unchanged.
- Back-to-back: with if_ready held high and single-cycle memory, sustained throughput is one instruction every 2 cycles (REQ/WAIT alternation).
- fetch_pc arithmetic is 64-bit and wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0 without error.

Optional Feature:
- Macro: YSYX_22051145_IF_PERF_EN.
- When defined, adds two outputs:
  - perf_fetch_cnt[63:0]: increments on every buffer push.
  - perf_flush_cnt[63:0]: increments on every cycle with jump_flag = 1.
  - Both reset to 0 and wrap on overflow.
- When undefined, neither the ports nor the counter logic exist, and all other behaviour is identical.

Test Plan:
- Reset release, memory ready and 1-cycle response, if_ready = 1:
  - imem_req_addr sequence 0x80000000, 0x80000004, 0x80000008.
  - if_pc follows the same sequence with matching if_inst.
- if_ready = 0 for 10 cycles:
  - Exactly 2 pushes, if_pc 0x80000000 head held stable, state IDLE, imem_req_valid = 0.
  - Releasing if_ready resumes fetch at 0x80000008.
- jump_flag with jump_addr = 0x80001003 while in WAIT, response 3 cycles later:
  - That response is dropped and the buffer is flushed.
  - Next request address is 0x80001000; the first if_pc after the redirect is 0x80001000.
- jump_flag in the same cycle as imem_rsp_valid:
  - The response is not pushed; next cycle imem_req_valid = 1 with the redirect target.
- rst asserted mid-WAIT, asynchronously between edges:
  - Outputs are immediately at reset values.
  - A late response after release is ignored; the first request after release is RESET_PC.
- With YSYX_22051145_IF_PERF_EN defined, 5 fetches and 2 redirects → perf_fetch_cnt = 5, perf_flush_cnt = 2.
